// File: rtl/vga_pkg.sv
// Shared 640x480@60 raster constants and RGB 4:4:4 helpers, used by the scan-out
// stage, the colour decoder and the game logic.
package vga_pkg;

    localparam int unsigned H_ACTIVE = 640;
    localparam int unsigned H_FP     = 16;
    localparam int unsigned H_SYNC   = 96;
    localparam int unsigned H_BP     = 48;
    localparam int unsigned H_TOTAL  = H_ACTIVE + H_FP + H_SYNC + H_BP;
    localparam int unsigned H_SYNC_START = H_ACTIVE + H_FP;
    localparam int unsigned H_SYNC_END   = H_SYNC_START + H_SYNC;

    localparam int unsigned V_ACTIVE = 480;
    localparam int unsigned V_FP     = 10;
    localparam int unsigned V_SYNC   = 2;
    localparam int unsigned V_BP     = 33;
    localparam int unsigned V_TOTAL  = V_ACTIVE + V_FP + V_SYNC + V_BP;
    localparam int unsigned V_SYNC_START = V_ACTIVE + V_FP;
    localparam int unsigned V_SYNC_END   = V_SYNC_START + V_SYNC;

    localparam int unsigned CNT_W = 10;
    localparam int unsigned RGB_W = 12;

    typedef logic [RGB_W-1:0] rgb_t;

    // Sync/blank flags that travel alongside the colour pipeline
    typedef struct packed {
        logic hs;
        logic vs;
        logic active;
    } scan_flags_t;

    localparam scan_flags_t FLAGS_RST = '{hs: 1'b1, vs: 1'b1, active: 1'b0};

    function automatic logic [3:0] rgb_r(input rgb_t c);
        return c[11:8];
    endfunction

    function automatic logic [3:0] rgb_g(input rgb_t c);
        return c[7:4];
    endfunction

    function automatic logic [3:0] rgb_b(input rgb_t c);
        return c[3:0];
    endfunction

endpackage

// File: rtl/vga_delay_line.sv
// Enable-gated shift register with a loadable reset value; DEPTH = 0 is a wire.
module vga_delay_line #(
    parameter int unsigned DEPTH = 2,
    parameter int unsigned WIDTH = 3
) (
    input  logic             clk,
    input  logic             rst_n,
    input  logic             i_en,
    input  logic [WIDTH-1:0] i_rst_val,
    input  logic [WIDTH-1:0] i_d,
    output logic [WIDTH-1:0] o_q
);

    generate
        if (DEPTH == 0) begin : g_pass
            assign o_q = i_d;
        end else begin : g_shift
            logic [WIDTH-1:0] r_stage [DEPTH];

            // Shift one stage per enabled step; reset loads every stage with i_rst_val
            always_ff @(posedge clk or negedge rst_n) begin
                if (!rst_n) begin
                    for (int i = 0; i < int'(DEPTH); i++) begin
                        r_stage[i] <= i_rst_val;
                    end
                end else if (i_en) begin
                    r_stage[0] <= i_d;
                    for (int i = 1; i < int'(DEPTH); i++) begin
                        r_stage[i] <= r_stage[i-1];
                    end
                end
            end

            assign o_q = r_stage[DEPTH-1];
        end
    endgenerate

endmodule

// File: rtl/vga_scan_out.sv
// Raster counters, sync decode and the registered VGA pin stage; sync/blank are
// delayed PIX_LAT steps so they line up with the colour returned for each coordinate.
module vga_scan_out
    import vga_pkg::*;
#(
    parameter int unsigned H_ACTIVE = vga_pkg::H_ACTIVE,
    parameter int unsigned H_FP     = vga_pkg::H_FP,
    parameter int unsigned H_SYNC   = vga_pkg::H_SYNC,
    parameter int unsigned H_BP     = vga_pkg::H_BP,
    parameter int unsigned V_ACTIVE = vga_pkg::V_ACTIVE,
    parameter int unsigned V_FP     = vga_pkg::V_FP,
    parameter int unsigned V_SYNC   = vga_pkg::V_SYNC,
    parameter int unsigned V_BP     = vga_pkg::V_BP,
    parameter int unsigned PIX_LAT  = 2
) (
    input  logic             clk,
    input  logic             rst_n,
    input  logic             pix_en,
    input  logic [11:0]      cl_to_vga,
    output logic [9:0]       pix_x,
    output logic [9:0]       pix_y,
    output logic             pix_active,
    output logic             frame_start,
    output logic             vga_hs,
    output logic             vga_vs,
    output logic [3:0]       vga_r,
    output logic [3:0]       vga_g,
    output logic [3:0]       vga_b
);

    localparam logic [9:0] H_ACT_C  = 10'(H_ACTIVE);
    localparam logic [9:0] H_LAST_C = 10'(H_ACTIVE + H_FP + H_SYNC + H_BP - 1);
    localparam logic [9:0] H_SS_C   = 10'(H_ACTIVE + H_FP);
    localparam logic [9:0] H_SE_C   = 10'(H_ACTIVE + H_FP + H_SYNC);
    localparam logic [9:0] V_ACT_C  = 10'(V_ACTIVE);
    localparam logic [9:0] V_LAST_C = 10'(V_ACTIVE + V_FP + V_SYNC + V_BP - 1);
    localparam logic [9:0] V_SS_C   = 10'(V_ACTIVE + V_FP);
    localparam logic [9:0] V_SE_C   = 10'(V_ACTIVE + V_FP + V_SYNC);

    logic [9:0]  r_h;
    logic [9:0]  r_v;
    logic        r_frame_start;
    logic        r_hs;
    logic        r_vs;
    rgb_t        r_rgb;

    logic        w_h_last;
    logic        w_v_last;
    scan_flags_t w_flags_raw;
    scan_flags_t w_flags_dly;

    // Raw decode of the current counter position
    always_comb begin
        w_h_last           = (r_h == H_LAST_C);
        w_v_last           = (r_v == V_LAST_C);
        w_flags_raw.active = (r_h < H_ACT_C) && (r_v < V_ACT_C);
        w_flags_raw.hs     = !((r_h >= H_SS_C) && (r_h < H_SE_C));
        w_flags_raw.vs     = !((r_v >= V_SS_C) && (r_v < V_SE_C));
    end

    // Horizontal/vertical counters; v only moves on an h wrap
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            r_h <= 10'd0;
            r_v <= 10'd0;
        end else if (pix_en) begin
            if (w_h_last) begin
                r_h <= 10'd0;
                r_v <= w_v_last ? 10'd0 : (r_v + 10'd1);
            end else begin
                r_h <= r_h + 10'd1;
            end
        end
    end

    // One-clk pulse on the enabled step that wraps the frame; self-clears next clk
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            r_frame_start <= 1'b0;
        end else begin
            r_frame_start <= pix_en & w_h_last & w_v_last;
        end
    end

    vga_delay_line #(
        .DEPTH (PIX_LAT),
        .WIDTH ($bits(scan_flags_t))
    ) u_flags_dly (
        .clk       (clk),
        .rst_n     (rst_n),
        .i_en      (pix_en),
        .i_rst_val (FLAGS_RST),
        .i_d       (w_flags_raw),
        .o_q       (w_flags_dly)
    );

    // Pin register: colour is only passed through while the aligned active bit is set,
    // so whatever the decoder drives during blanking never reaches the connector
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            r_hs  <= 1'b1;
            r_vs  <= 1'b1;
            r_rgb <= 12'h000;
        end else if (pix_en) begin
            r_hs  <= w_flags_dly.hs;
            r_vs  <= w_flags_dly.vs;
            r_rgb <= w_flags_dly.active ? cl_to_vga : 12'h000;
        end
    end

    assign pix_x       = r_h;
    assign pix_y       = r_v;
    assign pix_active  = w_flags_raw.active;
    assign frame_start = r_frame_start;
    assign vga_hs      = r_hs;
    assign vga_vs      = r_vs;
    assign vga_r       = rgb_r(r_rgb);
    assign vga_g       = rgb_g(r_rgb);
    assign vga_b       = rgb_b(r_rgb);

endmodule
